// File: rtl/crypt_sched_pkg.sv
// Shared types and constants for the crypt_sched sequencer and its arbiter.
package crypt_sched_pkg;

    localparam int DATA_W      = 16;
    localparam int KEY_W       = 5;
    localparam int CNT_W       = 4;
    localparam int TMO_W       = 8;
    localparam int DRAIN_DEF   = 2;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_DRAIN,
        ST_RESP
    } state_t;

endpackage

// File: rtl/crypt_rr_arb.sv
// Combinational round-robin pick: first valid requester at or above the pointer, with wrap.
module crypt_rr_arb
    import crypt_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] i_req_valid,
    input  logic [IDW-1:0]  i_rr_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    logic           w_found;
    logic [IDW-1:0] w_k;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_k     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_k = IDW'((32'(i_rr_ptr) + i) % NREQ);
            if (!w_found && i_req_valid[w_k]) begin
                w_found     = 1'b1;
                o_grant[w_k] = 1'b1;
                o_idx       = w_k;
            end
        end
    end

    assign o_any = |i_req_valid;

endmodule

// File: rtl/crypt_sched.sv
// Sequencer/arbiter for the three-stage crypto pipeline.
// Define CRYPT_SCHED_TIMEOUT_EN to enable the WAIT-state watchdog.
module crypt_sched
    import crypt_sched_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int DRAIN   = DRAIN_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic [NREQ*KEY_W-1:0]    req_key,
    output logic [NREQ-1:0]          req_ready,
    output logic                     core_ld,
    output logic                     core_start,
    output logic [DATA_W-1:0]        core_data,
    output logic [KEY_W-1:0]         core_key,
    input  logic                     core_done,
    input  logic [DATA_W-1:0]        core_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic                     rsp_err
);

    localparam int IDW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || DRAIN < 0 || DRAIN > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_err
        $error("crypt_sched: parameter out of range");
    end

    state_t              r_state;
    logic [IDW-1:0]      r_ptr;
    logic [IDW-1:0]      r_id;
    logic [DATA_W-1:0]   r_data;
    logic [KEY_W-1:0]    r_key;
    logic [CNT_W-1:0]    r_drain;
    logic                r_core_ld;
    logic                r_core_start;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
`ifdef CRYPT_SCHED_TIMEOUT_EN
    logic [TMO_W-1:0]    r_tmo;
    logic                r_err;
`endif

    logic [NREQ-1:0]     w_grant;
    logic [IDW-1:0]      w_idx;
    logic                w_any;
    logic [DATA_W-1:0]   w_sel_data;
    logic [KEY_W-1:0]    w_sel_key;

    crypt_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .i_req_valid (req_valid),
        .i_rr_ptr    (r_ptr),
        .o_grant     (w_grant),
        .o_idx       (w_idx),
        .o_any       (w_any)
    );

    assign w_sel_data = req_data[32'(w_idx)*DATA_W +: DATA_W];
    assign w_sel_key  = req_key[32'(w_idx)*KEY_W +: KEY_W];

    // Accept pulse is combinational so the requester sees it in the grant cycle itself.
    assign req_ready  = (r_state == ST_IDLE && !rst) ? w_grant : '0;
    assign core_ld    = r_core_ld;
    assign core_start = r_core_start;
    assign core_data  = r_data;
    assign core_key   = r_key;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_id     = r_id;
`ifdef CRYPT_SCHED_TIMEOUT_EN
    assign rsp_err    = r_err;
`else
    assign rsp_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_id         <= '0;
            r_data       <= '0;
            r_key        <= '0;
            r_drain      <= '0;
            r_core_ld    <= 1'b0;
            r_core_start <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
`ifdef CRYPT_SCHED_TIMEOUT_EN
            r_tmo        <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_core_ld    <= 1'b0;
            r_core_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_data    <= w_sel_data;
                        r_key     <= w_sel_key;
                        r_id      <= w_idx;
                        r_ptr     <= (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
                        r_core_ld <= 1'b1;
                        r_state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_core_start <= 1'b1;
                    r_state      <= ST_START;
                end
                ST_START: begin
                    r_drain <= CNT_W'(DRAIN);
`ifdef CRYPT_SCHED_TIMEOUT_EN
                    r_tmo   <= '0;
`endif
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_done) begin
                        if (DRAIN == 0) begin
                            r_rsp_data  <= core_result;
                            r_rsp_valid <= 1'b1;
`ifdef CRYPT_SCHED_TIMEOUT_EN
                            r_err       <= 1'b0;
`endif
                            r_state     <= ST_RESP;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end
`ifdef CRYPT_SCHED_TIMEOUT_EN
                    // Expiry only when done is absent: a same-cycle done completes normally.
                    else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                        r_rsp_data  <= '0;
                        r_rsp_valid <= 1'b1;
                        r_err       <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (r_tmo != '1) begin
                        r_tmo <= r_tmo + 1'b1;
                    end
`endif
                end
                ST_DRAIN: begin
                    r_drain <= r_drain - 1'b1;
                    if (r_drain == CNT_W'(1)) begin
                        r_rsp_data  <= core_result;
                        r_rsp_valid <= 1'b1;
`ifdef CRYPT_SCHED_TIMEOUT_EN
                        r_err       <= 1'b0;
`endif
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crypt_sched.sv
// Directed bench for crypt_sched: DRAIN=2 instance (TIMEOUT=8) plus a DRAIN=0 instance.
module tb_crypt_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready;
    logic [31:0] req_data;
    logic [9:0]  req_key;
    logic        core_ld, core_start, core_done, rsp_valid, rsp_ready, rsp_err;
    logic [15:0] core_data, core_result, rsp_data;
    logic [4:0]  core_key;
    logic [0:0]  rsp_id;

    logic [1:0]  req_valid0, req_ready0;
    logic        core_ld0, core_start0, core_done0, rsp_valid0, rsp_ready0, rsp_err0;
    logic [15:0] core_data0, core_result0, rsp_data0;
    logic [4:0]  core_key0;
    logic [0:0]  rsp_id0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    crypt_sched #(.NREQ(2), .DRAIN(2), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_key(req_key),
        .req_ready(req_ready), .core_ld(core_ld), .core_start(core_start), .core_data(core_data),
        .core_key(core_key), .core_done(core_done), .core_result(core_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .rsp_err(rsp_err)
    );

    crypt_sched #(.NREQ(2), .DRAIN(0), .TIMEOUT(8)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_data(req_data), .req_key(req_key),
        .req_ready(req_ready0), .core_ld(core_ld0), .core_start(core_start0), .core_data(core_data0),
        .core_key(core_key0), .core_done(core_done0), .core_result(core_result0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_data(rsp_data0), .rsp_id(rsp_id0),
        .rsp_err(rsp_err0)
    );

    typedef struct {
        logic [1:0]  valid;
        logic [15:0] d0, d1;
        logic [4:0]  k0, k1;
        logic [15:0] res;
        logic [1:0]  exp_ready;
        logic [15:0] exp_data;
        logic [4:0]  exp_key;
        int          exp_id;
    } vec_t;

    vec_t vecs[8];
    vec_t v_post;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered at a negedge with the DUT idle; returns at the negedge after the handshake.
    task automatic run_txn(input vec_t v, input int n);
        req_valid = v.valid; req_data = {v.d1, v.d0}; req_key = {v.k1, v.k0};
        rsp_ready = 1'b1; core_result = 16'hFFFF;
        #1 chk($sformatf("v%0d req_ready", n), 32'(req_ready), 32'(v.exp_ready));
        @(negedge clk);
        chk($sformatf("v%0d core_ld", n), 32'(core_ld), 1);
        chk($sformatf("v%0d core_data", n), 32'(core_data), 32'(v.exp_data));
        chk($sformatf("v%0d core_key", n), 32'(core_key), 32'(v.exp_key));
        chk($sformatf("v%0d ready_busy", n), 32'(req_ready), 0);
        @(negedge clk);
        chk($sformatf("v%0d core_start", n), 32'(core_start), 1);
        chk($sformatf("v%0d ld_drop", n), 32'(core_ld), 0);
        chk($sformatf("v%0d data_hold", n), 32'(core_data), 32'(v.exp_data));
        @(negedge clk);
        chk($sformatf("v%0d start_drop", n), 32'(core_start), 0);
        @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        chk($sformatf("v%0d early_valid", n), 32'(rsp_valid), 0);
        @(negedge clk);
        core_result = v.res;
        @(negedge clk);
        core_result = 16'hFFFF;
        chk($sformatf("v%0d rsp_valid", n), 32'(rsp_valid), 1);
        chk($sformatf("v%0d rsp_data", n), 32'(rsp_data), 32'(v.res));
        chk($sformatf("v%0d rsp_id", n), 32'(rsp_id), 32'(v.exp_id));
        chk($sformatf("v%0d rsp_err", n), 32'(rsp_err), 0);
        @(negedge clk);
        chk($sformatf("v%0d rsp_drop", n), 32'(rsp_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2'b01, 16'hA5A5, 16'h0000, 5'h13, 5'h00, 16'h1234, 2'b01, 16'hA5A5, 5'h13, 0};
        vecs[1] = '{2'b11, 16'h1111, 16'h2222, 5'h01, 5'h02, 16'h3333, 2'b10, 16'h2222, 5'h02, 1};
        vecs[2] = '{2'b11, 16'h1111, 16'h2222, 5'h01, 5'h02, 16'h4444, 2'b01, 16'h1111, 5'h01, 0};
        vecs[3] = '{2'b11, 16'h1111, 16'h2222, 5'h01, 5'h02, 16'h5555, 2'b10, 16'h2222, 5'h02, 1};
        vecs[4] = '{2'b11, 16'h1111, 16'h2222, 5'h01, 5'h02, 16'h6666, 2'b01, 16'h1111, 5'h01, 0};
        vecs[5] = '{2'b10, 16'h0000, 16'hFFFF, 5'h00, 5'h1F, 16'h0000, 2'b10, 16'hFFFF, 5'h1F, 1};
        vecs[6] = '{2'b10, 16'hDEAD, 16'h0001, 5'h0A, 5'h15, 16'h8001, 2'b10, 16'h0001, 5'h15, 1};
        vecs[7] = '{2'b01, 16'hC3C3, 16'h7777, 5'h1F, 5'h07, 16'h0F0F, 2'b01, 16'hC3C3, 5'h1F, 0};
        v_post  = '{2'b11, 16'h1111, 16'h2222, 5'h01, 5'h02, 16'h9999, 2'b01, 16'h1111, 5'h01, 0};

        rst = 1'b1; req_valid = '0; req_data = '0; req_key = '0; core_done = 1'b0;
        core_result = 16'hFFFF; rsp_ready = 1'b0;
        req_valid0 = '0; core_done0 = 1'b0; core_result0 = '0; rsp_ready0 = 1'b1;
        repeat (2) @(negedge clk);
        req_valid = 2'b11;
        #1 chk("reset req_ready", 32'(req_ready), 0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        chk("reset core_ld", 32'(core_ld), 0);
        chk("reset core_start", 32'(core_start), 0);
        chk("reset core_data", 32'(core_data), 0);
        chk("reset core_key", 32'(core_key), 0);
        chk("reset rsp_valid", 32'(rsp_valid), 0);
        chk("reset rsp_data", 32'(rsp_data), 0);
        chk("reset rsp_id", 32'(rsp_id), 0);
        chk("reset rsp_err", 32'(rsp_err), 0);
        chk("reset rsp_valid0", 32'(rsp_valid0), 0);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle req_ready", 32'(req_ready), 0);
            chk("idle core_ld", 32'(core_ld), 0);
        end

        for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

        // Backpressure: grant requester 1 (pointer is 1), hold rsp_ready low for 10 RESP cycles.
        req_valid = 2'b11; req_data = {16'h2222, 16'h1111}; req_key = {5'h02, 5'h01};
        rsp_ready = 1'b0;
        #1 chk("bp grant", 32'(req_ready), 32'(2'b10));
        repeat (4) @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        @(negedge clk);
        core_result = 16'hABCD;
        @(negedge clk);
        core_result = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            core_done = (i == 4);
            chk($sformatf("bp%0d rsp_valid", i), 32'(rsp_valid), 1);
            chk($sformatf("bp%0d rsp_data", i), 32'(rsp_data), 32'h0000ABCD);
            chk($sformatf("bp%0d rsp_id", i), 32'(rsp_id), 1);
            chk($sformatf("bp%0d rsp_err", i), 32'(rsp_err), 0);
            chk($sformatf("bp%0d req_ready", i), 32'(req_ready), 0);
            chk($sformatf("bp%0d core_ld", i), 32'(core_ld), 0);
            @(negedge clk);
        end
        core_done = 1'b0;
        chk("bp last valid", 32'(rsp_valid), 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp release idle", 32'(rsp_valid), 0);
        chk("bp next grant", 32'(req_ready), 32'(2'b01));

        // Reset while in WAIT with the pointer at 1.
        @(negedge clk);
        chk("rw core_ld", 32'(core_ld), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1; req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        chk("rw core_ld", 32'(core_ld), 0);
        chk("rw core_start", 32'(core_start), 0);
        chk("rw core_data", 32'(core_data), 0);
        chk("rw core_key", 32'(core_key), 0);
        chk("rw rsp_valid", 32'(rsp_valid), 0);
        chk("rw rsp_data", 32'(rsp_data), 0);
        chk("rw rsp_id", 32'(rsp_id), 0);
        chk("rw req_ready", 32'(req_ready), 0);
        run_txn(v_post, 8);

`ifdef CRYPT_SCHED_TIMEOUT_EN
        // Pointer is 1, only requester 0 asks: expiry with no done.
        req_valid = 2'b01; req_data = {16'h0000, 16'h7E7E}; req_key = {5'h00, 5'h04};
        #1 chk("to grant", 32'(req_ready), 32'(2'b01));
        req_valid = '0;
        core_result = 16'hFFFF;
        repeat (3) @(negedge clk);
        for (int i = 3; i <= 10; i++) begin
            chk($sformatf("to wait%0d", i), 32'(rsp_valid), 0);
            @(negedge clk);
        end
        chk("to rsp_valid", 32'(rsp_valid), 1);
        chk("to rsp_err", 32'(rsp_err), 1);
        chk("to rsp_data", 32'(rsp_data), 0);
        chk("to rsp_id", 32'(rsp_id), 0);
        @(negedge clk);
        chk("to drop", 32'(rsp_valid), 0);

        // core_done in the expiry cycle completes normally.
        req_valid = 2'b01;
        #1 chk("td grant", 32'(req_ready), 32'(2'b01));
        req_valid = '0;
        repeat (10) @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        chk("td no expiry", 32'(rsp_valid), 0);
        @(negedge clk);
        core_result = 16'h5A5A;
        chk("td draining", 32'(rsp_valid), 0);
        @(negedge clk);
        core_result = 16'hFFFF;
        chk("td rsp_valid", 32'(rsp_valid), 1);
        chk("td rsp_err", 32'(rsp_err), 0);
        chk("td rsp_data", 32'(rsp_data), 32'h00005A5A);
        @(negedge clk);
`endif

        // DRAIN=0 instance: done and result in the same WAIT cycle.
        req_valid0 = 2'b01; req_data = {16'h0000, 16'h1357}; req_key = {5'h00, 5'h0A};
        #1 chk("d0 grant", 32'(req_ready0), 32'(2'b01));
        @(negedge clk);
        req_valid0 = '0;
        chk("d0 core_ld", 32'(core_ld0), 1);
        chk("d0 core_data", 32'(core_data0), 32'h00001357);
        @(negedge clk);
        chk("d0 core_start", 32'(core_start0), 1);
        @(negedge clk);
        core_done0 = 1'b1; core_result0 = 16'hBEEF;
        chk("d0 early", 32'(rsp_valid0), 0);
        @(negedge clk);
        core_done0 = 1'b0; core_result0 = 16'h0000;
        chk("d0 rsp_valid", 32'(rsp_valid0), 1);
        chk("d0 rsp_data", 32'(rsp_data0), 32'h0000BEEF);
        chk("d0 rsp_id", 32'(rsp_id0), 0);
        chk("d0 rsp_err", 32'(rsp_err0), 0);
        @(negedge clk);
        chk("d0 drop", 32'(rsp_valid0), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
